// File: rtl/mips_rtype_encoder.sv
// mips_rtype_encoder
//   Accepts a small ALU operation request, encodes it as a MIPS R-type
//   instruction word, and drives it to an external ALU core. The word is held
//   for SETTLE_CYCLES cycles. The core's combinational result is then captured
//   and handed out on a one-cycle writeback strobe.
//
// Parameters
//   SETTLE_CYCLES  cycles instr is held stable before core_result is sampled (1..15)
//
// Ports
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   req_valid/req_ready   request handshake; ready only while idle
//   req_op                0 ADD 1 SUB 2 AND 3 OR 4 SLTU 5 ADDU 6 SLL 7 SRL 8 SRA, others illegal
//   req_rs/rt/rd/shamt    register indices and shift amount
//   instr, instr_valid    encoded instruction word to the core and its live flag
//   core_result           combinational result returned by the core
//   wb_en/addr/data       writeback strobe, destination register, captured result
//   err                   one-cycle pulse when an illegal op is accepted
//   issued_count          wrapping count of completed legal instructions

module mips_rtype_encoder #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [4:0]  req_rs,
  input  logic [4:0]  req_rt,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_shamt,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic [31:0] core_result,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        err,
  output logic [15:0] issued_count
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    SETTLE,
    WB
  } state_t;

  // The counter is loaded with SETTLE_CYCLES-1 so SETTLE lasts exactly
  // SETTLE_CYCLES cycles; its last edge is the one that samples core_result.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  settleCnt_q;
  logic [4:0]  rd_q;
  logic [31:0] instr_q;
  logic        instrValid_q;
  logic        wbEn_q;
  logic [4:0]  wbAddr_q;
  logic [31:0] wbData_q;
  logic        err_q;
  logic [15:0] issued_q;

  logic        opLegal;
  logic        opIsShift;
  logic [5:0]  funct;
  logic [31:0] encodedWord;

  // Decode the requested op into its funct code. Shifts take their operand
  // from rt and shamt, so rs is zeroed for them. All other ops zero shamt.
  always_comb begin
    opLegal   = 1'b1;
    opIsShift = 1'b0;
    funct     = 6'b000000;
    case (req_op)
      4'd0: funct = 6'b100000;
      4'd1: funct = 6'b100010;
      4'd2: funct = 6'b100100;
      4'd3: funct = 6'b100101;
      4'd4: funct = 6'b101011;
      4'd5: funct = 6'b100001;
      4'd6: begin funct = 6'b000000; opIsShift = 1'b1; end
      4'd7: begin funct = 6'b000010; opIsShift = 1'b1; end
      4'd8: begin funct = 6'b000011; opIsShift = 1'b1; end
      default: opLegal = 1'b0;
    endcase
    encodedWord = {6'b000000,
                   opIsShift ? 5'b00000 : req_rs,
                   req_rt,
                   req_rd,
                   opIsShift ? req_shamt : 5'b00000,
                   funct};
  end

  // Control FSM with all outputs registered. The instruction word is built
  // and stored on the acceptance edge, so later input changes cannot affect
  // it. The write strobe and the completion count are registered decodes of
  // WB, so they appear in the cycle after WB, SETTLE_CYCLES+2 edges after
  // acceptance. That cycle is already IDLE and can accept the next request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      settleCnt_q  <= 4'd0;
      rd_q         <= 5'd0;
      instr_q      <= 32'd0;
      instrValid_q <= 1'b0;
      wbEn_q       <= 1'b0;
      wbAddr_q     <= 5'd0;
      wbData_q     <= 32'd0;
      err_q        <= 1'b0;
      issued_q     <= 16'd0;
    end else begin
      wbEn_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (opLegal) begin
              instr_q      <= encodedWord;
              instrValid_q <= 1'b1;
              rd_q         <= req_rd;
              state_q      <= ISSUE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          settleCnt_q <= SETTLE_LOAD;
          state_q     <= SETTLE;
        end
        SETTLE: begin
          if (settleCnt_q == 4'd0) begin
            wbData_q     <= core_result;
            wbAddr_q     <= rd_q;
            instrValid_q <= 1'b0;
            state_q      <= WB;
          end else begin
            settleCnt_q <= settleCnt_q - 4'd1;
          end
        end
        WB: begin
          wbEn_q   <= (rd_q != 5'd0);
          issued_q <= issued_q + 16'd1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign instr        = instr_q;
  assign instr_valid  = instrValid_q;
  assign wb_en        = wbEn_q;
  assign wb_addr      = wbAddr_q;
  assign wb_data      = wbData_q;
  assign err          = err_q;
  assign issued_count = issued_q;

endmodule

// File: tb/tb_mips_rtype_encoder.sv
// Directed-vector testbench for mips_rtype_encoder. It uses two instances:
// dut1 with SETTLE_CYCLES=1 and dut4 with SETTLE_CYCLES=4. The two instances
// share every input except req_valid.

module tb_mips_rtype_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid1 = 1'b0;
  logic        valid4 = 1'b0;
  logic [3:0]  reqOp = 4'd0;
  logic [4:0]  reqRs = 5'd0;
  logic [4:0]  reqRt = 5'd0;
  logic [4:0]  reqRd = 5'd0;
  logic [4:0]  reqShamt = 5'd0;
  logic [31:0] coreResult = 32'd0;

  logic        ready1, instrValid1, wbEn1, err1;
  logic [31:0] instr1, wbData1;
  logic [4:0]  wbAddr1;
  logic [15:0] issued1;

  logic        ready4, instrValid4, wbEn4, err4;
  logic [31:0] instr4, wbData4;
  logic [4:0]  wbAddr4;
  logic [15:0] issued4;

  int          checkCount = 0;
  int          errorCount = 0;
  logic [15:0] expCount1 = 16'd0;

  mips_rtype_encoder #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid1), .req_ready(ready1),
    .req_op(reqOp), .req_rs(reqRs), .req_rt(reqRt), .req_rd(reqRd),
    .req_shamt(reqShamt), .instr(instr1), .instr_valid(instrValid1),
    .core_result(coreResult), .wb_en(wbEn1), .wb_addr(wbAddr1),
    .wb_data(wbData1), .err(err1), .issued_count(issued1)
  );

  mips_rtype_encoder #(.SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid4), .req_ready(ready4),
    .req_op(reqOp), .req_rs(reqRs), .req_rt(reqRt), .req_rd(reqRd),
    .req_shamt(reqShamt), .instr(instr4), .instr_valid(instrValid4),
    .core_result(coreResult), .wb_en(wbEn4), .wb_addr(wbAddr4),
    .wb_data(wbData4), .err(err4), .issued_count(issued4)
  );

  always #5 clk = ~clk;

  // Guard against a hung run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one complete operation through dut1 (SETTLE_CYCLES=1) and check each phase
  task automatic applyStimulus(input logic [3:0] op, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd,
                               input logic [4:0] sh, input logic [31:0] result,
                               input logic [31:0] expInstr);
    reqOp = op; reqRs = rs; reqRt = rt; reqRd = rd; reqShamt = sh;
    coreResult = result;
    valid1 = 1'b1;
    tick();
    valid1 = 1'b0;
    checkOutput("issue instr", instr1, expInstr);
    checkOutput("issue instr_valid", 32'(instrValid1), 32'd1);
    checkOutput("issue req_ready", 32'(ready1), 32'd0);
    tick();
    checkOutput("settle instr_valid", 32'(instrValid1), 32'd1);
    tick();
    checkOutput("wb-state wb_en", 32'(wbEn1), 32'd0);
    checkOutput("wb-state instr_valid", 32'(instrValid1), 32'd0);
    tick();
    expCount1 = expCount1 + 16'd1;
    checkOutput("wb_en", 32'(wbEn1), (rd != 5'd0) ? 32'd1 : 32'd0);
    checkOutput("wb_addr", 32'(wbAddr1), 32'(rd));
    checkOutput("wb_data", wbData1, result);
    checkOutput("issued_count", 32'(issued1), 32'(expCount1));
    checkOutput("post req_ready", 32'(ready1), 32'd1);
    checkOutput("post instr hold", instr1, expInstr);
    checkOutput("post err", 32'(err1), 32'd0);
    tick();
    checkOutput("wb_en one cycle", 32'(wbEn1), 32'd0);
  endtask

  initial begin
    int lowCount;
    $display("[TB] starting mips_rtype_encoder bench");
    #1;
    checkOutput("reset instr", instr1, 32'd0);
    checkOutput("reset instr_valid", 32'(instrValid1), 32'd0);
    checkOutput("reset wb_en", 32'(wbEn1), 32'd0);
    checkOutput("reset wb_data", wbData1, 32'd0);
    checkOutput("reset issued", 32'(issued1), 32'd0);
    checkOutput("reset err", 32'(err1), 32'd0);
    checkOutput("reset ready", 32'(ready4), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // Encoding vectors, including the rs/shamt forcing cases
    applyStimulus(4'd0, 5'd1,  5'd2,  5'd3,  5'd0,  32'h0000_0007, 32'h0022_1820);
    applyStimulus(4'd8, 5'd9,  5'd4,  5'd5,  5'd3,  32'hFFFF_FFF0, 32'h0004_28C3);
    applyStimulus(4'd1, 5'd1,  5'd2,  5'd3,  5'd7,  32'h1234_5678, 32'h0022_1822);
    checkOutput("sub shamt field", 32'(instr1[10:6]), 32'd0);
    applyStimulus(4'd2, 5'd4,  5'd5,  5'd6,  5'd0,  32'hA5A5_0000, 32'h0085_3024);
    applyStimulus(4'd6, 5'd7,  5'd8,  5'd9,  5'd31, 32'h0000_0100, 32'h0008_4FC0);
    applyStimulus(4'd4, 5'd31, 5'd30, 5'd29, 5'd0,  32'h0000_0001, 32'h03FE_E82B);
    applyStimulus(4'd5, 5'd1,  5'd1,  5'd1,  5'd0,  32'hDEAD_BEEF, 32'h0021_0821);
    applyStimulus(4'd7, 5'd5,  5'd2,  5'd2,  5'd1,  32'h0000_0002, 32'h0002_1042);
    // rd=0: full sequence, no write strobe, still counted
    applyStimulus(4'd3, 5'd2,  5'd3,  5'd0,  5'd0,  32'h0000_00FF, 32'h0043_0025);

    // Illegal op: error pulse only
    reqOp = 4'd12;
    valid1 = 1'b1;
    tick();
    valid1 = 1'b0;
    checkOutput("illegal err", 32'(err1), 32'd1);
    checkOutput("illegal instr_valid", 32'(instrValid1), 32'd0);
    checkOutput("illegal ready", 32'(ready1), 32'd1);
    checkOutput("illegal wb_en", 32'(wbEn1), 32'd0);
    tick();
    checkOutput("illegal err one cycle", 32'(err1), 32'd0);
    checkOutput("illegal issued", 32'(issued1), 32'(expCount1));

    // Counter wrap: preload near the top, then run one more op
    force dut1.issued_q = 16'hFFFF;
    tick();
    release dut1.issued_q;
    expCount1 = 16'hFFFF;
    checkOutput("preload issued", 32'(issued1), 32'h0000_FFFF);
    applyStimulus(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0000_0007, 32'h0022_1820);
    checkOutput("wrap issued", 32'(issued1), 32'd0);

    // SETTLE_CYCLES=4: back-to-back requests, late sampling, latched fields
    reqOp = 4'd0; reqRs = 5'd1; reqRt = 5'd2; reqRd = 5'd3; reqShamt = 5'd0;
    valid4 = 1'b1;
    tick();
    checkOutput("s4 first instr", instr4, 32'h0022_1820);
    lowCount = 0;
    for (int n = 0; n < 20 && !ready4; n++) begin
      lowCount++;
      coreResult = 32'hC0DE_0000 + 32'(n);
      reqOp = 4'd1; reqRs = 5'd10; reqRt = 5'd11; reqRd = 5'd12; reqShamt = 5'd9;
      checkOutput("s4 instr stable", instr4, 32'h0022_1820);
      tick();
    end
    checkOutput("s4 ready low cycles", 32'(lowCount), 32'd6);
    checkOutput("s4 wb_en", 32'(wbEn4), 32'd1);
    checkOutput("s4 wb_addr", 32'(wbAddr4), 32'd3);
    checkOutput("s4 wb_data sample", wbData4, 32'hC0DE_0004);
    checkOutput("s4 issued", 32'(issued4), 32'd1);
    tick();
    checkOutput("s4 second instr", instr4, 32'h014B_6022);
    lowCount = 0;
    for (int n = 0; n < 20 && !ready4; n++) begin
      lowCount++;
      tick();
    end
    valid4 = 1'b0;
    checkOutput("s4 second ready low", 32'(lowCount), 32'd6);
    checkOutput("s4 second wb_addr", 32'(wbAddr4), 32'd12);
    tick();
    tick();

    // Reset during SETTLE abandons the instruction
    reqOp = 4'd0; reqRs = 5'd1; reqRt = 5'd2; reqRd = 5'd7;
    coreResult = 32'h5555_AAAA;
    valid4 = 1'b1;
    tick();
    valid4 = 1'b0;
    tick();
    tick();
    checkOutput("pre-reset instr_valid", 32'(instrValid4), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async instr", instr4, 32'd0);
    checkOutput("async instr_valid", 32'(instrValid4), 32'd0);
    checkOutput("async wb_data", wbData4, 32'd0);
    checkOutput("async wb_addr", 32'(wbAddr4), 32'd0);
    checkOutput("async issued", 32'(issued4), 32'd0);
    checkOutput("async ready", 32'(ready4), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      tick();
      checkOutput("no wb after reset", 32'(wbEn4), 32'd0);
    end
    checkOutput("ready after reset", 32'(ready4), 32'd1);
    checkOutput("issued after reset", 32'(issued4), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
